// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: datapath width, the NOP encoding, the IF->ID
// payload and the pcsource encodings that drive a redirect flush.
package cpu_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc4;
    logic [WORD_W-1:0] ins;
  } if_id_t;

  typedef enum logic [1:0] {
    PCSRC_PC4    = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JR     = 2'b10,
    PCSRC_J      = 2'b11
  } pcsource_e;

  // Any pcsource other than sequential pc+4 redirects fetch.
  function automatic logic is_redirect(input pcsource_e src);
    return src != PCSRC_PC4;
  endfunction

endpackage

// File: rtl/pipe_if_id_buffer_sync_fifo.sv
// Small circular FIFO with occupancy count and a clear that drops all held
// entries without touching storage.
module sync_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * WORD_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer/count update; clear realigns the read pointer onto the write pointer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; validity is tracked solely by count.
  always_ff @(posedge clock) begin
    if (push && !clear) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);

endmodule

// File: rtl/pipe_if_id_buffer.sv
// IF->ID stage register with a skid queue: absorbs ID stalls, kills wrong-path
// fetches on redirect, and masks the ID-side instruction to NOP when empty.
module pipe_if_id_buffer
  import cpu_pkg::*;
#(
  parameter int unsigned      WIDTH = WORD_W,
  parameter int unsigned      DEPTH = 2,
  parameter logic [WIDTH-1:0] NOP   = WIDTH'(NOP_INST)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc4,
  input  logic [WIDTH-1:0] ins,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic             flush,
  input  logic             id_ready,
  output logic             id_valid,
  output logic [WIDTH-1:0] dpc4,
  output logic [WIDTH-1:0] inst
);

  logic               push, pop;
  logic               full, empty;
  logic [2*WIDTH-1:0] rd_data;

  // Ready/valid depend only on held occupancy, never on id_ready.
  assign if_ready = !full;
  assign id_valid = !empty;
  assign push     = if_valid && if_ready && !flush;
  assign pop      = id_valid && id_ready && !flush;

  sync_fifo #(
    .WIDTH (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .clear   (flush),
    .wr_data ({pc4, ins}),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );

  assign dpc4 = id_valid ? rd_data[2*WIDTH-1:WIDTH] : '0;
  assign inst = id_valid ? rd_data[WIDTH-1:0]       : NOP;

endmodule
